ray_gen: RTL and testbench

RAY_GEN -- requirements
Module: ray_gen

---
 rtl/raytrace_pkg.sv | 36 +++
 rtl/vec3_acc.sv | 38 +++
 rtl/ray_gen.sv | 209 ++++++++++++++++++++
 tb/tb_ray_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raytrace_pkg.sv
// Shared types and constants for the ray-generation pipeline.
package raytrace_pkg;

  // Q16.16 fixed-point format used by every coordinate lane.
  localparam int unsigned FRAC        = 16;
  localparam int unsigned LANE_W      = 32;
  localparam int unsigned VEC3_W      = 3 * LANE_W;

  // Ray bus layout: origin in the low half, direction in the high half.
  localparam int unsigned RAY_ORG_LSB = 0;
  localparam int unsigned RAY_DIR_LSB = VEC3_W;
  localparam int unsigned RAY_W       = 2 * VEC3_W;

  // x occupies the least-significant lane, z the most-significant.
  typedef struct packed {
    logic signed [LANE_W-1:0] z;
    logic signed [LANE_W-1:0] y;
    logic signed [LANE_W-1:0] x;
  } vec3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } raygen_state_t;

  // Per-lane 32-bit two's-complement add; carries wrap within each lane.
  function automatic vec3_t vec3_add(input vec3_t a, input vec3_t b);
    vec3_t r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    r.z = a.z + b.z;
    return r;
  endfunction

endpackage

// File: rtl/vec3_acc.sv
// Registered 3-lane accumulator: load replaces the value, add steps it by i_inc.
module vec3_acc
  import raytrace_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rstn,
  input  logic  i_load,
  input  vec3_t i_load_val,
  input  logic  i_add,
  input  vec3_t i_inc,
  output vec3_t o_acc
);

  vec3_t acc_q;
  vec3_t acc_d;

  // Load has priority over add; otherwise hold.
  always_comb begin
    acc_d = acc_q;
    if (i_load) begin
      acc_d = i_load_val;
    end else if (i_add) begin
      acc_d = vec3_add(acc_q, i_inc);
    end
  end

  // Accumulator register with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/ray_gen.sv
// Camera ray generator: walks a width x height pixel grid and emits one
// {direction, origin} ray per pixel over a valid/ready handshake.
// Directions are built incrementally (dir += du along a row, rowdir += dv
// per row) so no multipliers are needed.
// Optional feature: define RAYGEN_ABORT_EN to add i_abort, which ends a
// running frame early with a normal o_done pulse.
module ray_gen
  import raytrace_pkg::*;
#(
  parameter int unsigned DIM_W = 16,
  parameter int unsigned FRAC  = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [95:0]        i_eye,
  input  logic [95:0]        i_ll,
  input  logic [95:0]        i_du,
  input  logic [95:0]        i_dv,
  input  logic [DIM_W-1:0]   i_width,
  input  logic [DIM_W-1:0]   i_height,
  output logic [191:0]       o_ray,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DIM_W-1:0]   o_px,
  output logic [DIM_W-1:0]   o_py,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done
`ifdef RAYGEN_ABORT_EN
  ,
  input  logic               i_abort
`endif
);

  // FRAC only documents the coordinate format; the datapath is plain
  // integer addition and works for any binary point position.
  if (FRAC != raytrace_pkg::FRAC) begin : g_nonstd_frac
  end

  raygen_state_t state_q, state_d;

  vec3_t            eye_q, eye_d;
  vec3_t            du_q, du_d;
  vec3_t            dv_q, dv_d;
  logic [DIM_W-1:0] width_q, width_d;
  logic [DIM_W-1:0] height_q, height_d;
  logic [DIM_W-1:0] px_q, px_d;
  logic [DIM_W-1:0] py_q, py_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  vec3_t dir_q;
  vec3_t row_q;
  logic  dir_load, dir_add;
  vec3_t dir_load_val;
  logic  row_load, row_add;
  vec3_t row_step_c;
  logic  abort_req;

`ifdef RAYGEN_ABORT_EN
  assign abort_req = i_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Direction of the first pixel of the next row.
  assign row_step_c = vec3_add(row_q, dv_q);

  // Next-state, counter and accumulator control.
  always_comb begin
    state_d      = state_q;
    eye_d        = eye_q;
    du_d         = du_q;
    dv_d         = dv_q;
    width_d      = width_q;
    height_d     = height_q;
    px_d         = px_q;
    py_d         = py_q;
    dir_load     = 1'b0;
    dir_add      = 1'b0;
    dir_load_val = vec3_t'(i_ll);
    row_load     = 1'b0;
    row_add      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          eye_d    = vec3_t'(i_eye);
          du_d     = vec3_t'(i_du);
          dv_d     = vec3_t'(i_dv);
          width_d  = i_width;
          height_d = i_height;
          px_d     = '0;
          py_d     = '0;
          if ((i_width == '0) || (i_height == '0)) begin
            state_d = DONE;
          end else begin
            state_d  = RUN;
            dir_load = 1'b1;
            row_load = 1'b1;
          end
        end
      end

      RUN: begin
        if (valid_q && i_ready) begin
          if (px_q != (width_q - DIM_W'(1))) begin
            // Step along the row.
            px_d    = px_q + DIM_W'(1);
            dir_add = 1'b1;
          end else if (py_q != (height_q - DIM_W'(1))) begin
            // Wrap to the start of the next row without a bubble.
            px_d         = '0;
            py_d         = py_q + DIM_W'(1);
            row_add      = 1'b1;
            dir_load     = 1'b1;
            dir_load_val = row_step_c;
          end else begin
            state_d = DONE;
          end
        end
        if (abort_req) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Output flags registered from the upcoming state.
    valid_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    last_d  = valid_d && (px_d == (width_d - DIM_W'(1))) &&
              (py_d == (height_d - DIM_W'(1)));
  end

  // State, latched frame parameters, counters and output flags.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      eye_q    <= '0;
      du_q     <= '0;
      dv_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
      px_q     <= '0;
      py_q     <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      eye_q    <= eye_d;
      du_q     <= du_d;
      dv_q     <= dv_d;
      width_q  <= width_d;
      height_q <= height_d;
      px_q     <= px_d;
      py_q     <= py_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Current ray direction.
  vec3_acc u_dir_acc (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (dir_load),
    .i_load_val (dir_load_val),
    .i_add      (dir_add),
    .i_inc      (du_q),
    .o_acc      (dir_q)
  );

  // Direction of the first pixel of the current row.
  vec3_acc u_row_acc (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (row_load),
    .i_load_val (vec3_t'(i_ll)),
    .i_add      (row_add),
    .i_inc      (dv_q),
    .o_acc      (row_q)
  );

  assign o_ray[RAY_DIR_LSB +: VEC3_W] = dir_q;
  assign o_ray[RAY_ORG_LSB +: VEC3_W] = eye_q;
  assign o_valid = valid_q;
  assign o_px    = px_q;
  assign o_py    = py_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_ray_gen.sv
// Bench for ray_gen: a frame-level model expands each accepted frame into its
// full list of expected rays (dir = ll + px*du + py*dv) and a compare process
// checks outputs against it every cycle; directed scenarios add literal checks.
module tb_ray_gen;

  localparam int unsigned DW = 16;

  logic           clk = 1'b0;
  logic           i_rstn, i_start, i_ready, i_abort;
  logic [95:0]    i_eye, i_ll, i_du, i_dv;
  logic [DW-1:0]  i_width, i_height;
  logic [191:0]   o_ray;
  logic           o_valid, o_last, o_busy, o_done;
  logic [DW-1:0]  o_px, o_py;

  always #5 clk = ~clk;

  ray_gen #(.DIM_W(DW), .FRAC(16)) dut (
    .i_clk   (clk),
    .i_rstn  (i_rstn),
    .i_start (i_start),
    .i_eye   (i_eye),
    .i_ll    (i_ll),
    .i_du    (i_du),
    .i_dv    (i_dv),
    .i_width (i_width),
    .i_height(i_height),
    .o_ray   (o_ray),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_px    (o_px),
    .o_py    (o_py),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done)
`ifdef RAYGEN_ABORT_EN
    ,
    .i_abort (i_abort)
`endif
  );

  typedef struct packed {
    logic [191:0]  ray;
    logic [DW-1:0] px;
    logic [DW-1:0] py;
  } exp_t;

  exp_t mq[$];
  logic m_done_due = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_xfer = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  // Expand a frame into its ordered list of rays.
  task automatic model_load(input logic [95:0] eye, input logic [95:0] ll, input logic [95:0] du,
                            input logic [95:0] dv, input logic [DW-1:0] w, input logic [DW-1:0] h);
    for (int y = 0; y < int'(h); y++) begin
      for (int x = 0; x < int'(w); x++) begin
        exp_t        e;
        logic [95:0] d;
        for (int l = 0; l < 3; l++) begin
          d[32*l +: 32] = ll[32*l +: 32] + 32'(x) * du[32*l +: 32] + 32'(y) * dv[32*l +: 32];
        end
        e.ray = {d, eye};
        e.px  = DW'(x);
        e.py  = DW'(y);
        mq.push_back(e);
      end
    end
  endtask

  // Per-cycle compare and model advance, sampled on the falling edge.
  initial begin
    logic exp_valid, next_done;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_valid = (mq.size() != 0);
      check("valid", 192'(o_valid), 192'(exp_valid));
      check("done",  192'(o_done),  192'(m_done_due));
      check("busy",  192'(o_busy),  192'(exp_valid || m_done_due));
      if (exp_valid) begin
        check("ray",  o_ray,       mq[0].ray);
        check("px",   192'(o_px),  192'(mq[0].px));
        check("py",   192'(o_py),  192'(mq[0].py));
        check("last", 192'(o_last), 192'(mq.size() == 1));
      end else begin
        check("last_idle", 192'(o_last), 192'(0));
      end
      next_done = 1'b0;
      if (!i_rstn) begin
        mq.delete();
      end else begin
        if (exp_valid && i_ready) begin
          void'(mq.pop_front());
          n_xfer++;
          if (mq.size() == 0) next_done = 1'b1;
        end
        if (exp_valid && i_abort && (mq.size() != 0)) begin
          mq.delete();
          next_done = 1'b1;
        end
        if (!exp_valid && !m_done_due && i_start) begin
          model_load(i_eye, i_ll, i_du, i_dv, i_width, i_height);
          if (mq.size() == 0) next_done = 1'b1;
        end
      end
      m_done_due = next_done;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [95:0] eye, input logic [95:0] ll, input logic [95:0] du,
                             input logic [95:0] dv, input logic [DW-1:0] w, input logic [DW-1:0] h);
    i_eye = eye; i_ll = ll; i_du = du; i_dv = dv; i_width = w; i_height = h;
    i_start = 1'b1;
    cyc();
    i_start  = 1'b0;
    i_eye    = {$urandom, $urandom, $urandom};
    i_ll     = {$urandom, $urandom, $urandom};
    i_du     = {$urandom, $urandom, $urandom};
    i_dv     = {$urandom, $urandom, $urandom};
    i_width  = DW'($urandom_range(1, 9));
    i_height = DW'($urandom_range(1, 9));
  endtask

  // Run until o_done is seen, optionally toggling i_ready 1,0,0,1,...
  task automatic wait_done(input bit bp, input int budget);
    bit   seen;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bp) i_ready = pat[i % 4];
      @(negedge clk);
      if (o_done === 1'b1) seen = 1'b1;
      else cyc();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: no o_done within %0d cycles", budget);
    end
    i_ready = 1'b1;
    cyc();
  endtask

  localparam logic [31:0] P1 = 32'h0001_0000;
  localparam logic [31:0] M1 = 32'hFFFF_0000;

  initial begin
    logic [95:0] lit [4];
    int          x0;
    lit[0] = v3(M1, M1, M1);
    lit[1] = v3(P1, M1, M1);
    lit[2] = v3(M1, P1, M1);
    lit[3] = v3(P1, P1, M1);

    i_rstn = 1'b0; i_start = 1'b0; i_ready = 1'b1; i_abort = 1'b0;
    i_eye = '0; i_ll = '0; i_du = '0; i_dv = '0; i_width = '0; i_height = '0;
    repeat (2) cyc();
    @(negedge clk);
    check("rst_ray",   o_ray,        192'(0));
    check("rst_px",    192'(o_px),   192'(0));
    check("rst_py",    192'(o_py),   192'(0));
    check("rst_valid", 192'(o_valid), 192'(0));
    check("rst_busy",  192'(o_busy),  192'(0));
    i_rstn = 1'b1;
    cyc();

    // Basic 2x2 frame with literal directions.
    start_frame(v3(0, 0, P1), v3(M1, M1, M1), v3(32'h0002_0000, 0, 0), v3(0, 32'h0002_0000, 0), 2, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_valid", 192'(o_valid), 192'(1));
      check("t1_dir",   192'(o_ray[191:96]), 192'(lit[k]));
      check("t1_org",   192'(o_ray[95:0]),   192'(v3(0, 0, P1)));
      check("t1_last",  192'(o_last), 192'(k == 3));
    end
    @(negedge clk);
    check("t1_done", 192'(o_done), 192'(1));
    cyc();

    // Same frame under backpressure.
    x0 = n_xfer;
    start_frame(v3(0, 0, P1), v3(M1, M1, M1), v3(32'h0002_0000, 0, 0), v3(0, 32'h0002_0000, 0), 2, 2);
    wait_done(1'b1, 40);
    check("t2_xfers", 192'(n_xfer - x0), 192'(4));

    // Zero width.
    start_frame(v3(1, 2, 3), v3(4, 5, 6), v3(7, 8, 9), v3(1, 1, 1), 0, 3);
    @(negedge clk);
    check("t3_done",  192'(o_done),  192'(1));
    check("t3_valid", 192'(o_valid), 192'(0));
    cyc();
    @(negedge clk);
    check("t3_idle", 192'(o_busy), 192'(0));
    cyc();

    // Lane wrap, ignored start during RUN, then a fresh frame.
    start_frame(v3(5, 6, 7), v3(32'h7FFF_0000, 0, 0), v3(P1, 0, 0), v3(0, 0, 0), 2, 1);
    i_start = 1'b1; i_width = 5; i_height = 5;
    @(negedge clk);
    cyc();
    i_start = 1'b0;
    @(negedge clk);
    check("t4_wrap_x", 192'(o_ray[127:96]), 192'(32'h8000_0000));
    check("t4_last",   192'(o_last), 192'(1));
    cyc();
    wait_done(1'b0, 10);
    x0 = n_xfer;
    start_frame(v3(9, 9, 9), v3(M1, P1, 3), v3(3, 0, 32'hFFFF_FFFF), v3(0, 7, 1), 3, 2);
    wait_done(1'b1, 60);
    check("t4_xfers", 192'(n_xfer - x0), 192'(6));

    // Reset in the middle of a frame.
    start_frame(v3(1, 1, 1), v3(0, 0, 0), v3(1, 2, 3), v3(4, 5, 6), 3, 3);
    cyc();
    cyc();
    i_rstn = 1'b0;
    cyc();
    @(negedge clk);
    check("t5_ray",   o_ray,        192'(0));
    check("t5_px",    192'(o_px),   192'(0));
    check("t5_py",    192'(o_py),   192'(0));
    check("t5_valid", 192'(o_valid), 192'(0));
    check("t5_last",  192'(o_last),  192'(0));
    check("t5_busy",  192'(o_busy),  192'(0));
    check("t5_done",  192'(o_done),  192'(0));
    cyc();
    i_rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_no_done", 192'(o_done), 192'(0));
    end
    cyc();

`ifdef RAYGEN_ABORT_EN
    // Abort on ray 1 of a 4x4 frame.
    x0 = n_xfer;
    start_frame(v3(0, 0, 0), v3(1, 2, 3), v3(P1, 0, 0), v3(0, P1, 0), 4, 4);
    cyc();
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    @(negedge clk);
    check("t6_valid", 192'(o_valid), 192'(0));
    check("t6_done",  192'(o_done),  192'(1));
    check("t6_xfers", 192'(n_xfer - x0), 192'(2));
    cyc();
    @(negedge clk);
    check("t6_single_done", 192'(o_done), 192'(0));
    cyc();
`endif

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
